// File: rtl/decoder_n_scan.sv
// One-hot SEL_W-to-2^SEL_W decoder with enable and a dwell-timed scan mode.
// All outputs registered; wrap pulses when the scan returns to position 0.
module decoder_n_scan #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      a,
  input  logic                  load,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] z,
  output logic                  en_out,
  output logic                  wrap
);

  localparam int N = 1 << SEL_W;

  logic [N-1:0]       z_d, z_q;
  logic               en_out_d, en_out_q;
  logic               wrap_d, wrap_q;
  logic [SEL_W-1:0]   idx_d, idx_q;
  logic [DWELL_W-1:0] cnt_d, cnt_q;
  logic [DWELL_W-1:0] dwell_d, dwell_q;
  logic               mode_d, mode_q;

  function automatic logic [N-1:0] onehot(
    input logic [SEL_W-1:0] i
  );
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mode_d  = mode;
    z_d     = '0;
    wrap_d  = 1'b0;
    if (mode && !mode_q) begin
      idx_d = a;
      cnt_d = '0;
      z_d   = en ? onehot(a) : '0;
    end else if (mode) begin
      if (en) begin
        // a load takes the place of a step that falls due
        if (!load) begin
          if (cnt_q != dwell_q) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d  = '0;
            idx_d  = idx_q + 1'b1;
            wrap_d = &idx_q;
          end
        end
        z_d = onehot(idx_d);
      end
    end else begin
      z_d = en ? onehot(a) : '0;
    end
    if (load) begin
      dwell_d = dwell;
      cnt_d   = '0;
    end
    en_out_d = |z_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q      <= '0;
      en_out_q <= 1'b0;
      wrap_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      mode_q   <= 1'b0;
    end else begin
      z_q      <= z_d;
      en_out_q <= en_out_d;
      wrap_q   <= wrap_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      mode_q   <= mode_d;
    end
  end

  assign z      = z_q;
  assign en_out = en_out_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Bench for decoder_n_scan: table-driven vectors on a 2-bit and a 3-bit
// instance, expected results queued at drive time and popped after the edge.
module tb_decoder_n_scan;

  typedef struct {
    int         inst;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] a;
    logic       load;
    logic [7:0] dwell;
    logic [7:0] z;
    logic       wrap;
  } vec_t;

  typedef struct {
    int         inst;
    int         row;
    logic [7:0] z;
    logic       wrap;
  } exp_t;

  logic       clk;
  logic       rst0, en0, mode0, load0;
  logic [1:0] a0;
  logic [7:0] dwell0;
  logic [3:0] z0;
  logic       en_out0, wrap0;

  logic       rst1, en1, mode1, load1;
  logic [2:0] a1;
  logic [3:0] dwell1;
  logic [7:0] z1;
  logic       en_out1, wrap1;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks;
  int   errors;

  decoder_n_scan #(.SEL_W(2), .DWELL_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst0), .en(en0), .mode(mode0),
    .a(a0), .load(load0), .dwell(dwell0),
    .z(z0), .en_out(en_out0), .wrap(wrap0)
  );

  decoder_n_scan #(.SEL_W(3), .DWELL_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst1), .en(en1), .mode(mode1),
    .a(a1), .load(load1), .dwell(dwell1),
    .z(z1), .en_out(en_out1), .wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic r0(
    input logic rst, input logic en, input logic mode,
    input logic [2:0] a, input logic load, input logic [7:0] dw,
    input logic [7:0] z, input logic w
  );
    vecs.push_back('{0, rst, en, mode, a, load, dw, z, w});
  endtask

  task automatic r1(
    input logic rst, input logic en, input logic mode,
    input logic [2:0] a, input logic load, input logic [7:0] dw,
    input logic [7:0] z, input logic w
  );
    vecs.push_back('{1, rst, en, mode, a, load, dw, z, w});
  endtask

  task automatic check_out();
    exp_t       e;
    logic [7:0] az;
    logic       aw, ae;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    if (e.inst == 0) begin
      az = {4'b0, z0};
      aw = wrap0;
      ae = en_out0;
    end else begin
      az = z1;
      aw = wrap1;
      ae = en_out1;
    end
    checks++;
    if (az !== e.z) begin
      errors++;
      $display("FAIL z inst%0d row%0d: got %h expected %h",
               e.inst, e.row, az, e.z);
    end
    checks++;
    if (aw !== e.wrap) begin
      errors++;
      $display("FAIL wrap inst%0d row%0d: got %b expected %b",
               e.inst, e.row, aw, e.wrap);
    end
    checks++;
    if (ae !== (e.z != 8'h00)) begin
      errors++;
      $display("FAIL en_out inst%0d row%0d: got %b expected %b",
               e.inst, e.row, ae, (e.z != 8'h00));
    end
  endtask

  task automatic apply(input vec_t t, input int row);
    if (t.inst == 0) begin
      rst0   = t.rst_n;
      en0    = t.en;
      mode0  = t.mode;
      a0     = t.a[1:0];
      load0  = t.load;
      dwell0 = t.dwell;
    end else begin
      rst1   = t.rst_n;
      en1    = t.en;
      mode1  = t.mode;
      a1     = t.a;
      load1  = t.load;
      dwell1 = t.dwell[3:0];
    end
    sb.push_back('{t.inst, row, t.z, t.wrap});
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    vec_t       t;
    logic [7:0] ez;
    checks = 0;
    errors = 0;
    rst0 = 1'b0; en0 = 1'b0; mode0 = 1'b0;
    a0 = '0; load0 = 1'b0; dwell0 = '0;
    rst1 = 1'b0; en1 = 1'b0; mode1 = 1'b0;
    a1 = '0; load1 = 1'b0; dwell1 = '0;

    // reset, then release with a=3
    r0(0,1,0,3,0,0,8'h0,0);
    r0(0,1,0,3,0,0,8'h0,0);
    r0(0,1,0,3,0,0,8'h0,0);
    r0(1,1,0,3,0,0,8'h8,0);
    // direct decode and disable
    r0(1,1,0,0,0,0,8'h1,0);
    r0(1,1,0,1,0,0,8'h2,0);
    r0(1,1,0,2,0,0,8'h4,0);
    r0(1,1,0,3,0,0,8'h8,0);
    r0(1,0,0,2,0,0,8'h0,0);
    // scan from 2, dwell 0
    r0(1,1,1,2,0,0,8'h4,0);
    r0(1,1,1,0,0,0,8'h8,0);
    r0(1,1,1,0,0,0,8'h1,1);
    r0(1,1,1,0,0,0,8'h2,0);
    r0(1,1,1,0,0,0,8'h4,0);
    r0(1,1,1,0,0,0,8'h8,0);
    r0(1,1,1,0,0,0,8'h1,1);
    // load dwell 2 mid-scan
    r0(1,1,1,0,1,2,8'h1,0);
    r0(1,1,1,0,0,0,8'h1,0);
    r0(1,1,1,0,0,0,8'h1,0);
    for (int i = 0; i < 3; i++) r0(1,1,1,0,0,0,8'h2,0);
    for (int i = 0; i < 3; i++) r0(1,1,1,0,0,0,8'h4,0);
    for (int i = 0; i < 3; i++) r0(1,1,1,0,0,0,8'h8,0);
    r0(1,1,1,0,0,0,8'h1,1);
    r0(1,1,1,0,0,0,8'h1,0);
    r0(1,1,1,0,0,0,8'h1,0);
    r0(1,1,1,0,0,0,8'h2,0);
    r0(1,1,1,0,0,0,8'h2,0);
    r0(1,1,1,0,0,0,8'h2,0);
    // load on a due step: no step, count restarts
    r0(1,1,1,0,1,2,8'h2,0);
    r0(1,1,1,0,0,0,8'h2,0);
    r0(1,1,1,0,0,0,8'h2,0);
    r0(1,1,1,0,0,0,8'h4,0);
    // load in direct mode, re-enter scan at 1, pause and resume
    r0(1,1,0,1,1,3,8'h2,0);
    r0(1,1,1,1,0,0,8'h2,0);
    r0(1,1,1,0,0,0,8'h2,0);
    r0(1,0,1,0,0,0,8'h0,0);
    r0(1,0,1,0,0,0,8'h0,0);
    r0(1,0,1,0,0,0,8'h0,0);
    r0(1,1,1,0,0,0,8'h2,0);
    r0(1,1,1,0,0,0,8'h2,0);
    for (int i = 0; i < 4; i++) r0(1,1,1,0,0,0,8'h4,0);
    r0(1,1,1,0,0,0,8'h8,0);
    // back to direct
    r0(1,1,0,0,0,0,8'h1,0);

    // 3-bit instance: scan from 6 with dwell 1, reset mid-scan
    r1(0,1,0,6,0,0,8'h00,0);
    r1(0,1,0,6,0,0,8'h00,0);
    r1(1,1,0,6,1,1,8'h40,0);
    r1(1,1,1,6,0,0,8'h40,0);
    r1(1,1,1,6,0,0,8'h40,0);
    r1(1,1,1,6,0,0,8'h80,0);
    r1(1,1,1,6,0,0,8'h80,0);
    r1(1,1,1,6,0,0,8'h01,1);
    r1(1,1,1,6,0,0,8'h01,0);
    r1(1,1,1,6,0,0,8'h02,0);
    r1(0,1,1,6,0,0,8'h00,0);
    r1(0,1,1,6,0,0,8'h00,0);
    r1(1,1,1,6,0,0,8'h40,0);
    r1(1,1,1,6,0,0,8'h80,0);
    r1(1,1,1,6,0,0,8'h01,1);
    r1(1,1,1,6,0,0,8'h02,0);

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      apply(t, i);
    end

    // random direct-mode vectors on the 2-bit instance
    for (int i = 0; i < 12; i++) begin
      t.inst  = 0;
      t.rst_n = 1'b1;
      t.en    = 1'($urandom_range(0, 1));
      t.mode  = 1'b0;
      t.a     = 3'($urandom_range(0, 3));
      t.load  = 1'b0;
      t.dwell = 8'h00;
      ez      = 8'h00;
      if (t.en) ez[t.a[1:0]] = 1'b1;
      t.z     = ez;
      t.wrap  = 1'b0;
      apply(t, 1000 + i);
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
